// File: rtl/mac_job_seq_pkg.sv
// Shared widths, mode/state encodings and cfg-word layout for the mac_cluster job sequencer.
package mac_job_seq_pkg;

  localparam int MAC_MIN_WIDTH  = 16;
  localparam int MAC_ACC_WIDTH  = 32;
  localparam int MAC_CONF_WIDTH = 3;
  localparam int MAC_LANES      = 4;

  localparam int OP_W        = MAC_LANES * MAC_MIN_WIDTH;
  localparam int RES_W       = MAC_LANES * MAC_ACC_WIDTH;
  localparam int CFG_W       = RES_W + MAC_CONF_WIDTH;
  localparam int CFG_ACC_BIT = MAC_CONF_WIDTH - 1;

  typedef enum logic [1:0] {
    MAC_SINGLE       = 2'b00,
    MAC_DUAL         = 2'b01,
    MAC_QUAD         = 2'b10,
    MAC_MODE_ILLEGAL = 2'b11
  } mac_mode_e;

  typedef enum logic [2:0] {
    MAC_SEQ_IDLE  = 3'd0,
    MAC_SEQ_LOAD  = 3'd1,
    MAC_SEQ_RUN   = 3'd2,
    MAC_SEQ_DRAIN = 3'd3,
    MAC_SEQ_RESP  = 3'd4
  } seq_state_e;

  function automatic int cfg_init_lsb(input int n);
    return MAC_CONF_WIDTH + n * MAC_ACC_WIDTH;
  endfunction

  // mode in the low bits, accumulate flag on top of the conf field, init0..init3 ascending above it
  function automatic logic [CFG_W-1:0] pack_cfg(input mac_mode_e mode, input logic acc,
                                                input logic [RES_W-1:0] init);
    logic [CFG_W-1:0] cfg;
    cfg = '0;
    cfg[MAC_CONF_WIDTH-2:0] = mode;
    cfg[CFG_ACC_BIT] = acc;
    for (int n = 0; n < MAC_LANES; n++) begin
      cfg[cfg_init_lsb(n) +: MAC_ACC_WIDTH] = init[n*MAC_ACC_WIDTH +: MAC_ACC_WIDTH];
    end
    return cfg;
  endfunction

endpackage

// File: rtl/mac_job_seq_if.sv
// Host-side job port: command, operand stream and result, each valid/ready.
interface mac_job_seq_if #(
  parameter int LEN_W = 16
);
  import mac_job_seq_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic             cmd_acc;
  logic [LEN_W-1:0] cmd_len;
  logic [RES_W-1:0] cmd_init;

  logic             op_valid;
  logic             op_ready;
  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;

  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;
  logic             res_err;
  logic             busy;

  modport master (
    output cmd_valid, cmd_mode, cmd_acc, cmd_len, cmd_init,
    output op_valid, op_a, op_b, res_ready,
    input  cmd_ready, op_ready, res_valid, res_data, res_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_acc, cmd_len, cmd_init,
    input  op_valid, op_a, op_b, res_ready,
    output cmd_ready, op_ready, res_valid, res_data, res_err, busy
  );

endinterface

// File: rtl/mac_job_seq_cnt.sv
// Loadable down-counter with zero flag; load wins over decrement, decrement stops at zero.
module mac_job_seq_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/mac_job_seq.sv
// Job sequencer for one mac_cluster: load cfg, stream beats 1/cycle, drain MAC_LAT+1 cycles, hold result until res_ready.
// Last beat accepted at edge E gives res_valid after edge E+MAC_LAT+1; one job in flight, cmd_ready only in IDLE.
module mac_job_seq
  import mac_job_seq_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  mac_job_seq_if.slave     host,
  output logic             mac_rst,
  output logic             mac_en,
  output logic [OP_W-1:0]  mac_a,
  output logic [OP_W-1:0]  mac_b,
  output logic [CFG_W-1:0] mac_cfg,
  input  logic [RES_W-1:0] mac_out
);

  seq_state_e       state_q;
  logic             cmd_ready_q;
  logic             op_ready_q;
  logic             res_valid_q;
  logic             res_err_q;
  logic             busy_q;
  logic [RES_W-1:0] res_data_q;

  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;

  logic cmd_hs;
  logic beat_hs;
  logic last_beat;
  logic acc_mode;

  assign cmd_hs    = host.cmd_valid && cmd_ready_q;
  assign beat_hs   = host.op_valid && op_ready_q;
  assign last_beat = beat_hs && (cnt == LEN_W'(1));
  assign acc_mode  = mac_cfg[CFG_ACC_BIT];

  assign host.cmd_ready = cmd_ready_q;
  assign host.op_ready  = op_ready_q;
  assign host.res_valid = res_valid_q;
  assign host.res_err   = res_err_q;
  assign host.res_data  = res_data_q;
  assign host.busy      = busy_q;

  // One counter serves both phases: beats remaining in RUN, drain cycles remaining in DRAIN.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state_q)
      MAC_SEQ_IDLE: begin
        cnt_load = cmd_hs;
        cnt_val  = host.cmd_len;
      end
      MAC_SEQ_LOAD: begin
        cnt_load = cnt_zero;
        cnt_val  = LEN_W'(MAC_LAT);
      end
      MAC_SEQ_RUN: begin
        cnt_load = last_beat;
        cnt_val  = LEN_W'(MAC_LAT);
        cnt_dec  = beat_hs && !last_beat;
      end
      MAC_SEQ_DRAIN: cnt_dec = 1'b1;
      default: ;
    endcase
  end

  mac_job_seq_cnt #(.W(LEN_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MAC_SEQ_IDLE;
      cmd_ready_q <= 1'b1;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
      mac_rst     <= 1'b1;
      mac_en      <= 1'b0;
      mac_a       <= '0;
      mac_b       <= '0;
      mac_cfg     <= '0;
    end else begin
      case (state_q)
        MAC_SEQ_IDLE: begin
          if (cmd_hs) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (host.cmd_mode == MAC_MODE_ILLEGAL) begin
              state_q     <= MAC_SEQ_RESP;
              res_valid_q <= 1'b1;
              res_err_q   <= 1'b1;
              res_data_q  <= '0;
            end else begin
              state_q <= MAC_SEQ_LOAD;
              mac_cfg <= pack_cfg(mac_mode_e'(host.cmd_mode),
                                  host.cmd_acc || (host.cmd_len == '0), host.cmd_init);
              mac_rst <= 1'b1;
              mac_en  <= 1'b1;
              mac_a   <= '0;
              mac_b   <= '0;
            end
          end
        end
        MAC_SEQ_LOAD: begin
          mac_rst <= 1'b0;
          if (cnt_zero) begin
            state_q <= MAC_SEQ_DRAIN;
          end else begin
            state_q    <= MAC_SEQ_RUN;
            op_ready_q <= 1'b1;
          end
        end
        MAC_SEQ_RUN: begin
          if (beat_hs) begin
            mac_a <= host.op_a;
            mac_b <= host.op_b;
            if (last_beat) begin
              state_q    <= MAC_SEQ_DRAIN;
              op_ready_q <= 1'b0;
            end
          end else if (acc_mode) begin
            mac_a <= '0;
            mac_b <= '0;
          end
        end
        MAC_SEQ_DRAIN: begin
          // zero operands add nothing when accumulating; held operands repeat the product otherwise
          if (acc_mode) begin
            mac_a <= '0;
            mac_b <= '0;
          end
          if (cnt_zero) begin
            state_q     <= MAC_SEQ_RESP;
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b0;
            res_data_q  <= mac_out;
            mac_en      <= 1'b0;
          end
        end
        MAC_SEQ_RESP: begin
          if (host.res_ready) begin
            state_q     <= MAC_SEQ_IDLE;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            mac_rst     <= 1'b1;
            mac_en      <= 1'b0;
            mac_a       <= '0;
            mac_b       <= '0;
          end
        end
        default: state_q <= MAC_SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_job_seq.sv
// Bench for mac_job_seq with a behavioural mac_cluster and a result scoreboard.
module tb_mac_job_seq;
  import mac_job_seq_pkg::*;

  localparam int LEN_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic             mac_rst, mac_en;
  logic [OP_W-1:0]  mac_a, mac_b;
  logic [CFG_W-1:0] mac_cfg;
  logic [RES_W-1:0] mac_out;

  mac_job_seq_if #(.LEN_W(LEN_W)) hif ();

  mac_job_seq #(.LEN_W(LEN_W), .MAC_LAT(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (hif.slave),
    .mac_rst (mac_rst),
    .mac_en  (mac_en),
    .mac_a   (mac_a),
    .mac_b   (mac_b),
    .mac_cfg (mac_cfg),
    .mac_out (mac_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [RES_W-1:0] data;
    logic             err;
  } exp_t;
  exp_t sb[$];

  // Cluster model: operand product registered on the sampling edge, folded into the accumulators on the next.
  logic [127:0] m_acc = '0;
  logic [127:0] m_p   = '0;
  assign mac_out = m_acc;

  function automatic logic [127:0] prod(input logic [63:0] a, input logic [63:0] b, input logic [1:0] m);
    logic [127:0] r;
    r = '0;
    case (m)
      2'b00: for (int l = 0; l < 4; l++) r[l*32 +: 32] = 32'(a[l*16 +: 16]) * 32'(b[l*16 +: 16]);
      2'b01: for (int g = 0; g < 2; g++) r[g*64 +: 64] = 64'(a[g*32 +: 32]) * 64'(b[g*32 +: 32]);
      default: r = 128'(a) * 128'(b);
    endcase
    return r;
  endfunction

  function automatic logic [127:0] gadd(input logic [127:0] x, input logic [127:0] y, input logic [1:0] m);
    logic [127:0] r;
    r = '0;
    case (m)
      2'b00: for (int l = 0; l < 4; l++) r[l*32 +: 32] = x[l*32 +: 32] + y[l*32 +: 32];
      2'b01: for (int g = 0; g < 2; g++) r[g*64 +: 64] = x[g*64 +: 64] + y[g*64 +: 64];
      default: r = x + y;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (mac_en) begin
      if (mac_rst) begin
        m_acc <= mac_cfg[130:3];
        m_p   <= '0;
      end else begin
        m_p   <= prod(mac_a, mac_b, mac_cfg[1:0]);
        m_acc <= mac_cfg[2] ? gadd(m_acc, m_p, mac_cfg[1:0]) : m_p;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic expect_res(input logic [127:0] data, input logic err);
    sb.push_back(exp_t'{data: data, err: err});
  endtask

  always @(negedge clk) begin
    if (rst_n && hif.res_valid && hif.res_ready) begin
      if (sb.size() == 0) begin
        timeout("unexpected_result");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", hif.res_data, e.data);
        check("res_err", 128'(hif.res_err), 128'(e.err));
      end
    end
  end

  task automatic send_cmd(input logic [1:0] mode, input logic acc, input logic [15:0] len,
                          input logic [127:0] init);
    bit ok;
    ok = 0;
    hif.cmd_valid = 1'b1;
    hif.cmd_mode  = mode;
    hif.cmd_acc   = acc;
    hif.cmd_len   = len;
    hif.cmd_init  = init;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hif.cmd_ready) begin ok = 1; break; end
    end
    if (!ok) timeout("cmd_ready_wait");
    @(posedge clk); #1;
    hif.cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] a, input logic [63:0] b, output int e);
    bit ok;
    ok = 0;
    hif.op_valid = 1'b1;
    hif.op_a     = a;
    hif.op_b     = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hif.op_ready) begin ok = 1; break; end
    end
    if (!ok) timeout("op_ready_wait");
    @(posedge clk); #1;
    e = cyc;
    hif.op_valid = 1'b0;
  endtask

  task automatic wait_res(output int c);
    bit ok;
    ok = 0;
    c = cyc;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (hif.res_valid) begin ok = 1; c = cyc; break; end
    end
    if (!ok) timeout("res_valid_wait");
  endtask

  task automatic finish_job();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hif.res_valid && hif.res_ready) begin ok = 1; break; end
    end
    if (!ok) timeout("res_handshake_wait");
    @(posedge clk); #1;
    check("cmd_ready_after_resp", 128'(hif.cmd_ready), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, c;
    bit saw;
    hif.cmd_valid = 0; hif.cmd_mode = 0; hif.cmd_acc = 0; hif.cmd_len = 0; hif.cmd_init = 0;
    hif.op_valid = 0; hif.op_a = 0; hif.op_b = 0; hif.res_ready = 1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 128'({hif.cmd_ready, hif.op_ready, hif.res_valid, hif.res_err,
                              hif.busy, mac_rst, mac_en}), 128'(7'b1000010));
    check("reset_data", {hif.res_data, mac_a, mac_b}, '0);
    check("reset_cfg", 128'(mac_cfg), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single multiply 3*5 with latency check
    expect_res(128'hF, 1'b0);
    send_cmd(2'b00, 1'b0, 16'd1, '0);
    send_beat(64'h3, 64'h5, e);
    wait_res(c);
    check("single_latency", 128'(c - e), 128'(3));
    finish_job();

    // accumulate 100 + 2*3 + 4*5 with two bubbles, then without
    expect_res(128'd126, 1'b0);
    send_cmd(2'b00, 1'b1, 16'd2, 128'd100);
    send_beat(64'h2, 64'h3, e);
    repeat (2) @(posedge clk);
    #1;
    send_beat(64'h4, 64'h5, e);
    finish_job();

    expect_res(128'd126, 1'b0);
    send_cmd(2'b00, 1'b1, 16'd2, 128'd100);
    send_beat(64'h2, 64'h3, e);
    send_beat(64'h4, 64'h5, e);
    finish_job();

    // dual multiply 0x00010002 * 3
    expect_res(128'h0000_0000_0000_0000_0000_0000_0003_0006, 1'b0);
    send_cmd(2'b01, 1'b0, 16'd1, '0);
    send_beat(64'h0000_0000_0001_0002, 64'h0000_0000_0000_0003, e);
    finish_job();

    // quad multiply all-ones * 2
    expect_res(128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE, 1'b0);
    send_cmd(2'b10, 1'b0, 16'd1, '0);
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'h2, e);
    finish_job();

    // single-lane wrap: lane0 0xFFFFFFFF+1 -> 0 without carry, lane1 5+2 -> 7
    expect_res(128'h0000_0000_0000_0000_0000_0007_0000_0000, 1'b0);
    send_cmd(2'b00, 1'b1, 16'd1, 128'h0000_0000_0000_0000_0000_0005_FFFF_FFFF);
    send_beat(64'h0000_0000_0001_0001, 64'h0000_0000_0002_0001, e);
    finish_job();

    // len=0 returns init unchanged and never asks for operands
    expect_res(128'h0000_0009_0000_0000_0000_0000_0000_0007, 1'b0);
    send_cmd(2'b00, 1'b0, 16'd0, 128'h0000_0009_0000_0000_0000_0000_0000_0007);
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (hif.op_ready) saw = 1;
      if (hif.res_valid) break;
    end
    check("len0_no_op_ready", 128'(saw), '0);
    finish_job();

    // illegal mode: error response, cluster left in reset and disabled
    expect_res('0, 1'b1);
    send_cmd(2'b11, 1'b0, 16'd1, 128'hABCD);
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mac_rst || mac_en) saw = 1;
      if (hif.res_valid) break;
      @(posedge clk); #1;
    end
    check("illegal_cluster_untouched", 128'(saw), '0);
    finish_job();

    // reset mid-RUN after 1 of 4 beats
    send_cmd(2'b00, 1'b0, 16'd4, '0);
    send_beat(64'h1, 64'h1, e);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", 128'({hif.cmd_ready, hif.op_ready, hif.res_valid, hif.busy, mac_rst, mac_en}),
          128'(6'b100010));
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (hif.res_valid || hif.op_ready) saw = 1;
    end
    check("abort_no_result", 128'(saw), '0);
    check("abort_idle_ready", 128'({hif.cmd_ready, hif.busy}), 128'(2'b10));

    // clean job after abort, result held under res_ready=0
    expect_res(128'hF, 1'b0);
    hif.res_ready = 1'b0;
    send_cmd(2'b00, 1'b0, 16'd1, '0);
    send_beat(64'h3, 64'h5, e);
    wait_res(c);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 128'(hif.res_valid), 128'(1));
      check("stall_data", hif.res_data, 128'hF);
      @(posedge clk); #1;
    end
    hif.res_ready = 1'b1;
    finish_job();

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 128'(sb.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
